// File: rtl/cc_stats_pkg.sv
// Shared types and sizing for the connected-component statistics accumulator.
// Optional feature macro: CC_AREA_FILTER_EN (emit only labels with area >= MIN_AREA).
package cc_stats_pkg;

  // Coordinate counter width for a dimension of n positions
  function automatic int unsigned coord_w(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

  localparam int unsigned IMG_HDISP  = 1280;
  localparam int unsigned IMG_VDISP  = 720;
  localparam int unsigned LABEL_W    = 10;
  localparam int unsigned MAX_LABELS = 1 << LABEL_W;
  localparam int unsigned AREA_W     = 20;
  localparam int unsigned X_W        = coord_w(IMG_HDISP);
  localparam int unsigned Y_W        = coord_w(IMG_VDISP);
  localparam int unsigned PIX_LBL_W  = 32;

`ifdef CC_AREA_FILTER_EN
  localparam int unsigned MIN_AREA   = 16;
`endif

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_ACCUM    = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DUMP_RD  = 3'd4,
    ST_DUMP_OUT = 3'd5,
    ST_DONE     = 3'd6
  } state_e;

  typedef struct packed {
    logic [AREA_W-1:0] area;
    logic [X_W-1:0]    xmin;
    logic [X_W-1:0]    xmax;
    logic [Y_W-1:0]    ymin;
    logic [Y_W-1:0]    ymax;
  } entry_t;

endpackage

// File: rtl/cc_stats_ram.sv
// Per-label statistics table: one synchronous read port, one write port, no reset.
// A read and write to the same address in one cycle returns the old contents.
module cc_stats_ram
  import cc_stats_pkg::*;
(
  input  logic               clk,
  input  logic               we_i,
  input  logic [LABEL_W-1:0] waddr_i,
  input  entry_t             wdata_i,
  input  logic [LABEL_W-1:0] raddr_i,
  output entry_t             rdata_o
);

  entry_t mem_q [MAX_LABELS];

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read port
  always_ff @(posedge clk) begin
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/cc_stats_accum.sv
// Accumulates per-label area and bounding box over a frame, then streams one
// record per non-empty label and clears the table behind the dump.
// Optional feature macro: CC_AREA_FILTER_EN (records below MIN_AREA are cleared silently).
module cc_stats_accum
  import cc_stats_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 per_frame_vsync,
  input  logic                 per_frame_href,
  input  logic [PIX_LBL_W-1:0] per_label,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LABEL_W-1:0]   out_label,
  output logic [AREA_W-1:0]    out_area,
  output logic [X_W-1:0]       out_xmin,
  output logic [X_W-1:0]       out_xmax,
  output logic [Y_W-1:0]       out_ymin,
  output logic [Y_W-1:0]       out_ymax,
  output logic                 frame_done,
  output logic                 frame_drop,
  output logic                 busy
);

  localparam logic [LABEL_W-1:0] LAST_ADDR = LABEL_W'(MAX_LABELS - 1);
  localparam logic [AREA_W-1:0]  AREA_MAX  = '1;

  state_e state_q, state_d;

  logic               vsync_q, href_q;
  logic [LABEL_W-1:0] addr_q, addr_d;
  logic               phase_q, phase_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;

  logic               s1_valid_q, s1_valid_d;
  logic [LABEL_W-1:0] s1_label_q, s1_label_d;
  logic [X_W-1:0]     s1_x_q, s1_x_d;
  logic [Y_W-1:0]     s1_y_q, s1_y_d;

  logic               wb_valid_q;
  logic [LABEL_W-1:0] wb_addr_q;
  entry_t             wb_data_q;
  logic [LABEL_W-1:0] rd_addr_q;

  logic               ram_we;
  logic [LABEL_W-1:0] ram_waddr, ram_raddr;
  entry_t             ram_wdata, ram_rdata;
  entry_t             rd_fwd, upd;

  logic               out_valid_q, out_valid_d;
  logic [LABEL_W-1:0] out_label_q, out_label_d;
  entry_t             out_rec_q, out_rec_d;
  logic               frame_done_q, frame_done_d;
  logic               frame_drop_q, frame_drop_d;
  logic               busy_q, busy_d;

  logic vsync_rise_c, vsync_fall_c, href_fall_c, pix_ok_c;
  logic last_addr_c, emit_c, hand_c, drop_state_c;

  assign vsync_rise_c = per_frame_vsync & ~vsync_q;
  assign vsync_fall_c = ~per_frame_vsync & vsync_q;
  assign href_fall_c  = ~per_frame_href & href_q;
  assign pix_ok_c     = per_frame_vsync & per_frame_href
                      & (per_label[PIX_LBL_W-1:LABEL_W] == '0)
                      & (per_label[LABEL_W-1:0] != '0);
  assign last_addr_c  = (addr_q == LAST_ADDR);
  assign hand_c       = out_valid_q & out_ready;
  assign drop_state_c = (state_q inside {ST_INIT, ST_DRAIN, ST_DUMP_RD, ST_DUMP_OUT, ST_DONE});

  cc_stats_ram u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Forward the write from the previous cycle when it hit the address just read
  always_comb begin
    rd_fwd = ram_rdata;
    if (wb_valid_q && (wb_addr_q == rd_addr_q)) rd_fwd = wb_data_q;
  end

  // Merge the stage-1 pixel into its table entry
  always_comb begin
    upd = rd_fwd;
    if (rd_fwd.area == '0) begin
      upd.area = AREA_W'(1);
      upd.xmin = s1_x_q;
      upd.xmax = s1_x_q;
      upd.ymin = s1_y_q;
      upd.ymax = s1_y_q;
    end else begin
      if (rd_fwd.area != AREA_MAX) upd.area = rd_fwd.area + AREA_W'(1);
      if (s1_x_q < rd_fwd.xmin) upd.xmin = s1_x_q;
      if (s1_x_q > rd_fwd.xmax) upd.xmax = s1_x_q;
      if (s1_y_q < rd_fwd.ymin) upd.ymin = s1_y_q;
      if (s1_y_q > rd_fwd.ymax) upd.ymax = s1_y_q;
    end
  end

  // Decide whether the entry being dumped produces a record
  always_comb begin
`ifdef CC_AREA_FILTER_EN
    emit_c = (rd_fwd.area >= AREA_W'(MIN_AREA));
`else
    emit_c = (rd_fwd.area != '0);
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:     if (last_addr_c) state_d = ST_IDLE;
      ST_IDLE:     if (vsync_rise_c) state_d = ST_ACCUM;
      ST_ACCUM:    if (vsync_fall_c) state_d = ST_DRAIN;
      ST_DRAIN:    state_d = ST_DUMP_RD;
      ST_DUMP_RD: begin
        if (phase_q) begin
          if (emit_c)           state_d = ST_DUMP_OUT;
          else if (last_addr_c) state_d = ST_DONE;
        end
      end
      ST_DUMP_OUT: begin
        if (hand_c) state_d = last_addr_c ? ST_DONE : ST_DUMP_RD;
      end
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_INIT;
    endcase
  end

  // Datapath and output next-values per state
  always_comb begin
    ram_we       = 1'b0;
    ram_waddr    = addr_q;
    ram_wdata    = '0;
    ram_raddr    = addr_q;
    addr_d       = addr_q;
    phase_d      = phase_q;
    x_d          = x_q;
    y_d          = y_q;
    s1_valid_d   = 1'b0;
    s1_label_d   = s1_label_q;
    s1_x_d       = s1_x_q;
    s1_y_d       = s1_y_q;
    out_valid_d  = out_valid_q;
    out_label_d  = out_label_q;
    out_rec_d    = out_rec_q;
    frame_done_d = (state_q == ST_DONE);
    frame_drop_d = vsync_rise_c & drop_state_c;
    busy_d       = ~(state_d inside {ST_IDLE, ST_ACCUM});

    if (s1_valid_q) begin
      ram_we    = 1'b1;
      ram_waddr = s1_label_q;
      ram_wdata = upd;
    end

    case (state_q)
      ST_INIT: begin
        ram_we    = 1'b1;
        ram_waddr = addr_q;
        ram_wdata = '0;
        addr_d    = last_addr_c ? '0 : addr_q + LABEL_W'(1);
      end
      ST_IDLE: begin
        if (vsync_rise_c) begin
          x_d = '0;
          y_d = '0;
        end
      end
      ST_ACCUM: begin
        ram_raddr = per_label[LABEL_W-1:0];
        if (pix_ok_c) begin
          s1_valid_d = 1'b1;
          s1_label_d = per_label[LABEL_W-1:0];
          s1_x_d     = x_q;
          s1_y_d     = y_q;
        end
        if (per_frame_href) begin
          x_d = x_q + X_W'(1);
        end else if (href_fall_c) begin
          x_d = '0;
          y_d = y_q + Y_W'(1);
        end
      end
      ST_DRAIN: begin
        addr_d  = LABEL_W'(1);
        phase_d = 1'b0;
      end
      ST_DUMP_RD: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          ram_we    = 1'b1;
          ram_waddr = addr_q;
          ram_wdata = '0;
          phase_d   = 1'b0;
          if (emit_c) begin
            out_valid_d = 1'b1;
            out_label_d = addr_q;
            out_rec_d   = rd_fwd;
          end else if (!last_addr_c) begin
            addr_d = addr_q + LABEL_W'(1);
          end
        end
      end
      ST_DUMP_OUT: begin
        if (hand_c) begin
          out_valid_d = 1'b0;
          if (!last_addr_c) addr_d = addr_q + LABEL_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      addr_q       <= '0;
      phase_q      <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      s1_valid_q   <= 1'b0;
      s1_label_q   <= '0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      rd_addr_q    <= '0;
      out_valid_q  <= 1'b0;
      out_label_q  <= '0;
      out_rec_q    <= '0;
      frame_done_q <= 1'b0;
      frame_drop_q <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      vsync_q      <= per_frame_vsync;
      href_q       <= per_frame_href;
      addr_q       <= addr_d;
      phase_q      <= phase_d;
      x_q          <= x_d;
      y_q          <= y_d;
      s1_valid_q   <= s1_valid_d;
      s1_label_q   <= s1_label_d;
      s1_x_q       <= s1_x_d;
      s1_y_q       <= s1_y_d;
      wb_valid_q   <= ram_we;
      wb_addr_q    <= ram_waddr;
      wb_data_q    <= ram_wdata;
      rd_addr_q    <= ram_raddr;
      out_valid_q  <= out_valid_d;
      out_label_q  <= out_label_d;
      out_rec_q    <= out_rec_d;
      frame_done_q <= frame_done_d;
      frame_drop_q <= frame_drop_d;
      busy_q       <= busy_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_label  = out_label_q;
  assign out_area   = out_rec_q.area;
  assign out_xmin   = out_rec_q.xmin;
  assign out_xmax   = out_rec_q.xmax;
  assign out_ymin   = out_rec_q.ymin;
  assign out_ymax   = out_rec_q.ymax;
  assign frame_done = frame_done_q;
  assign frame_drop = frame_drop_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cc_stats_accum.sv
// Directed bench for cc_stats_accum: frames of hand-placed labels, records
// compared against hand-computed area and bounding boxes.
module tb_cc_stats_accum;
  import cc_stats_pkg::*;

  logic                 clk;
  logic                 rst;
  logic                 per_frame_vsync;
  logic                 per_frame_href;
  logic [PIX_LBL_W-1:0] per_label;
  logic                 out_valid;
  logic                 out_ready;
  logic [LABEL_W-1:0]   out_label;
  logic [AREA_W-1:0]    out_area;
  logic [X_W-1:0]       out_xmin, out_xmax;
  logic [Y_W-1:0]       out_ymin, out_ymax;
  logic                 frame_done, frame_drop, busy;

  typedef struct {
    int label; int area; int xmin; int xmax; int ymin; int ymax;
  } exp_rec_t;

  exp_rec_t exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  cc_stats_accum dut (
    .clk             (clk),
    .rst             (rst),
    .per_frame_vsync (per_frame_vsync),
    .per_frame_href  (per_frame_href),
    .per_label       (per_label),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_label       (out_label),
    .out_area        (out_area),
    .out_xmin        (out_xmin),
    .out_xmax        (out_xmax),
    .out_ymin        (out_ymin),
    .out_ymax        (out_ymax),
    .frame_done      (frame_done),
    .frame_drop      (frame_drop),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] cur_la();
    return 64'({out_label, out_area});
  endfunction

  function automatic logic [63:0] cur_bb();
    return 64'({out_xmin, out_xmax, out_ymin, out_ymax});
  endfunction

  function automatic logic [63:0] exp_la(input exp_rec_t e);
    return 64'({LABEL_W'(e.label), AREA_W'(e.area)});
  endfunction

  function automatic logic [63:0] exp_bb(input exp_rec_t e);
    return 64'({X_W'(e.xmin), X_W'(e.xmax), Y_W'(e.ymin), Y_W'(e.ymax)});
  endfunction

  task automatic push_exp(input int l, input int a, input int x0, input int x1,
                          input int y0, input int y1);
    exp_rec_t e;
    e.label = l; e.area = a; e.xmin = x0; e.xmax = x1; e.ymin = y0; e.ymax = y1;
`ifdef CC_AREA_FILTER_EN
    if (a >= int'(MIN_AREA)) exp_q.push_back(e);
`else
    if (a != 0) exp_q.push_back(e);
`endif
  endtask

  function automatic logic [31:0] label_at(input int pat, input int x, input int y);
    case (pat)
      1: if (x >= 10 && x <= 13 && y >= 20 && y <= 22) return 32'd5;
      2: return 32'd7;
      3: begin
        if (x <= 4 && y <= 3) return 32'd3;
        if (x >= 8 && x <= 9 && y >= 1 && y <= 2) return 32'd9;
      end
      6: begin
        if (x == 0) return 32'h0000_0400;
        if (x == 1) return 32'h0000_0405;
        if (x == 2) return 32'h8000_0003;
      end
      default: ;
    endcase
    return 32'd0;
  endfunction

  task automatic send_frame(input int pat, input int nlines, input int width);
    @(negedge clk);
    per_frame_vsync = 1'b1; per_frame_href = 1'b0; per_label = '0;
    repeat (2) @(negedge clk);
    for (int y = 0; y < nlines; y++) begin
      for (int x = 0; x < width; x++) begin
        @(negedge clk);
        if (x == 0 && y == 0) check("busy_low_accum", 64'(busy), 64'd0);
        per_frame_href = 1'b1;
        per_label = label_at(pat, x, y);
      end
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        per_frame_href = 1'b0; per_label = '0;
      end
    end
    @(negedge clk);
    per_frame_vsync = 1'b0;
  endtask

  task automatic run_dump(input int stall_first, input int drop_at,
                          output int drops, output int nrec);
    int stall_left;
    logic holding, done, was_held;
    logic [63:0] hold_la, hold_bb;
    exp_rec_t e;
    stall_left = stall_first;
    holding = 1'b0; done = 1'b0; was_held = 1'b0;
    hold_la = '0; hold_bb = '0;
    drops = 0; nrec = 0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge clk);
      if (frame_drop) drops++;
      if (was_held) check("valid_held_without_ready", 64'(out_valid), 64'd1);
      was_held = 1'b0;
      if (frame_done) begin
        done = 1'b1;
        check("records_left_at_done", 64'(exp_q.size()), 64'd0);
        check("idle_after_done", 64'(busy), 64'd0);
      end else if (out_valid) begin
        if (!holding) begin
          holding = 1'b1;
          hold_la = cur_la();
          hold_bb = cur_bb();
          check("busy_during_dump", 64'(busy), 64'd1);
        end else begin
          check("stall_label_area", cur_la(), hold_la);
          check("stall_bbox", cur_bb(), hold_bb);
        end
        if (stall_left > 0) begin
          stall_left--;
          out_ready = 1'b0;
          was_held = 1'b1;
        end else begin
          out_ready = 1'b1;
          holding = 1'b0;
          nrec++;
          check("record_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rec_label_area", cur_la(), exp_la(e));
            check("rec_bbox", cur_bb(), exp_bb(e));
          end
        end
      end else begin
        out_ready = ((cyc % 2) == 1);
      end
      if (drop_at >= 0) begin
        if (cyc == drop_at) per_frame_vsync = 1'b1;
        if (cyc > drop_at + 2 && cyc < drop_at + 13) begin
          per_frame_href = 1'b1; per_label = 32'd11;
        end else begin
          per_frame_href = 1'b0; per_label = '0;
        end
      end
    end
    if (!done) check("dump_timeout", 64'd1, 64'd0);
    out_ready = 1'b0;
    per_frame_href = 1'b0;
    per_label = '0;
    exp_q.delete();
  endtask

  initial begin
    int n, drops, nrec;
    rst = 1'b1;
    per_frame_vsync = 1'b0; per_frame_href = 1'b0; per_label = '0; out_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", cur_la() | cur_bb(), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_frame_drop", 64'(frame_drop), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);

    // INIT clears the table for MAX_LABELS cycles
    rst = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("init_cycles", 64'(n), 64'(MAX_LABELS));
    repeat (3) @(negedge clk);

    // 4x3 block of label 5
    push_exp(5, 12, 10, 13, 20, 22);
    send_frame(1, 23, 16);
    run_dump(0, -1, drops, nrec);
    check("no_drop_f1", 64'(drops), 64'd0);

    // Full line of label 7, back-to-back updates
    push_exp(7, 1280, 0, 1279, 0, 0);
    send_frame(2, 1, 1280);
    run_dump(0, -1, drops, nrec);

    // Labels 3 (area 20) and 9 (area 4)
    push_exp(3, 20, 0, 4, 0, 3);
    push_exp(9, 4, 8, 9, 1, 2);
    send_frame(3, 4, 12);
    run_dump(0, -1, drops, nrec);

    // Same frame, consumer stalls 50 cycles on the first record
    push_exp(3, 20, 0, 4, 0, 3);
    push_exp(9, 4, 8, 9, 1, 2);
    send_frame(3, 4, 12);
    run_dump(50, -1, drops, nrec);

    // Table must have been cleared: areas do not accumulate
    push_exp(3, 20, 0, 4, 0, 3);
    push_exp(9, 4, 8, 9, 1, 2);
    send_frame(3, 4, 12);
    run_dump(0, -1, drops, nrec);

    // vsync rises during the dump: that frame is dropped, dump completes
    push_exp(5, 12, 10, 13, 20, 22);
    send_frame(1, 23, 16);
    run_dump(0, 1, drops, nrec);
    check("drop_pulse_count", 64'(drops), 64'd1);
    repeat (20) @(negedge clk);
    per_frame_vsync = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_after_drop_valid", 64'(out_valid), 64'd0);

    // Next frame reported normally, no trace of the dropped frame's label 11
    push_exp(5, 12, 10, 13, 20, 22);
    send_frame(1, 23, 16);
    run_dump(0, -1, drops, nrec);
    check("no_drop_after", 64'(drops), 64'd0);

    // Background and out-of-range labels produce no records
    send_frame(6, 2, 8);
    run_dump(0, -1, drops, nrec);
    check("no_records_bad_labels", 64'(nrec), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
